lsu_bus_if: RTL

- Load/store bus interface for the pipelined core's MEM stage.
- Takes load/store requests from the EX/MEM pipeline register and runs a req/gnt/rvalid handshake with data memory. Stalls the pipeline while the access is outstanding.
- Stores: generates byte enables and replicated write data.
- Loads: delivers the raw 32-bit word, funct3 and byte offset to the downstream load-alignment stage, which performs sign/zero extension.

---
 rtl/lsu_bus_if.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_if.sv
// Load/store bus interface: MEM-stage access -> req/gnt/rvalid handshake with data memory.
// Latency: req 1 cycle after issue; ld_valid 1 cycle after rvalid; store done 1 cycle after gnt.
// Backpressure: stall held while the access is outstanding; bus_* held stable until bus_gnt.
module lsu_bus_if #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [3:0]       bus_be,
    output logic [WIDTH-1:0] bus_wdata,
    input  logic             bus_gnt,
    input  logic             bus_rvalid,
    input  logic [WIDTH-1:0] bus_rdata,
    output logic             stall,
    output logic             ld_valid,
    output logic [WIDTH-1:0] ld_word,
    output logic [2:0]       ld_funct3,
    output logic [1:0]       ld_offset,
    output logic             misalign,
    output logic             bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q;
    logic [WIDTH-1:0] addr_q, wdata_q;
    logic [3:0]       be_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [WIDTH-1:0] ld_word_q;
    logic [2:0]       ld_funct3_q;
    logic [1:0]       ld_offset_q;
    logic             bus_err_q;

    logic             access, start, timeout, ld_done;
    logic [1:0]       off;
    logic [3:0]       be_new;
    logic [WIDTH-1:0] wdata_new;

    assign access = mem_read | mem_write;
    assign off    = addr[1:0];

    always_comb begin
        misalign = 1'b0;
        if (state_q == S_IDLE && access) begin
            misalign = (funct3[1:0] == 2'b11)
                     | ((funct3[1:0] == 2'b01) & off[0])
                     | ((funct3[1:0] == 2'b10) & (off != 2'b00))
                     | (mem_write & funct3[2]);
        end
    end

    assign start = (state_q == S_IDLE) & access & ~misalign;
    assign stall = start | (state_q == S_REQ) | (state_q == S_WAIT);

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata;
        case (funct3[1:0])
            2'b00: begin
                wdata_new = {4{wdata[7:0]}};
                if (mem_write) be_new = 4'b0001 << off;
            end
            2'b01: begin
                wdata_new = {2{wdata[15:0]}};
                if (mem_write) be_new = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_new = wdata;
                be_new    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                cnt_d = '0;
                if (bus_gnt) state_d = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_d = S_DONE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ld_done = (state_q == S_WAIT) & (bus_rvalid | timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            ld_word_q   <= '0;
            ld_funct3_q <= '0;
            ld_offset_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= timeout;
            if (start) begin
                we_q    <= mem_write;
                addr_q  <= {addr[WIDTH-1:2], 2'b00};
                wdata_q <= wdata_new;
                be_q    <= be_new;
                f3_q    <= funct3;
                off_q   <= off;
            end
            // A timed-out load still completes, but with a zero word so nothing stale leaks downstream.
            if (ld_done) begin
                ld_word_q   <= bus_rvalid ? bus_rdata : '0;
                ld_funct3_q <= f3_q;
                ld_offset_q <= off_q;
            end
        end
    end

    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign ld_valid  = (state_q == S_DONE) & ~we_q;
    assign ld_word   = ld_word_q;
    assign ld_funct3 = ld_funct3_q;
    assign ld_offset = ld_offset_q;
    assign bus_err   = bus_err_q;

endmodule
